// File: rtl/mux2_stream_arbiter.sv
// Two-input valid/ready arbiter feeding a registered 2:1 mux stage.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed priority for input a.
module mux2_stream_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sel,
    input  logic              out_ready
);

    logic              out_valid_reg;
    logic              out_sel_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              free;
    logic              grant_a;
    logic              grant_b;
    logic              take;

`ifndef ARB_FIXED_PRIO_EN
    logic              last_a_reg;
`endif

    always_comb begin
        free = ~out_valid_reg | out_ready;
`ifdef ARB_FIXED_PRIO_EN
        grant_a = a_valid;
`else
        // On a tie, hand the slot to whichever side lost last time.
        grant_a = a_valid & (~b_valid | ~last_a_reg);
`endif
        grant_b = b_valid & ~grant_a;
        // Readies are forced low while reset is asserted, even between clock edges.
        a_ready = rst_n & free & grant_a;
        b_ready = rst_n & free & grant_b;
        take    = a_ready | b_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_sel_reg   <= 1'b0;
            out_data_reg  <= '0;
        end else if (free) begin
            if (take) begin
                out_valid_reg <= 1'b1;
                out_sel_reg   <= grant_a;
                out_data_reg  <= grant_a ? a_data : b_data;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_a_reg <= 1'b0;
        end else if (take) begin
            last_a_reg <= grant_a;
        end
    end
`endif

    assign out_valid = out_valid_reg;
    assign out_sel   = out_sel_reg;
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Scoreboard bench for mux2_stream_arbiter; build with ARB_FIXED_PRIO_EN for the fixed-priority variant.
module tb_mux2_stream_arbiter;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              a_valid = 1'b0;
    logic [DATA_W-1:0] a_data = '0;
    logic              a_ready;
    logic              b_valid = 1'b0;
    logic [DATA_W-1:0] b_data = '0;
    logic              b_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_sel;
    logic              out_ready = 1'b0;

    logic [DATA_W:0]   exp_q[$];
    logic [DATA_W:0]   exp_word;
    int                checks = 0;
    int                errors = 0;

    mux2_stream_arbiter #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({out_valid, out_sel, out_data, a_ready, b_ready} !== '0) begin
            errors++;
            $display("FAIL reset_init: valid=%b sel=%b data=%h ar=%b br=%b, want all 0",
                     out_valid, out_sel, out_data, a_ready, b_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        a_valid = 1'b1; a_data = 8'h55; out_ready = 1'b0;
        exp_q.push_back({1'b1, 8'h55});
        tick();
        checks++;
        exp_word = exp_q.pop_front();
        if (out_valid !== 1'b1 || {out_sel, out_data} !== exp_word) begin
            errors++;
            $display("FAIL reset_pre_word: valid=%b got %h want %h", out_valid, {out_sel, out_data}, exp_word);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_sel, out_data, a_ready, b_ready} !== '0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b sel=%b data=%h ar=%b br=%b, want all 0",
                     out_valid, out_sel, out_data, a_ready, b_ready);
        end
        $display("reset mid-stream: valid=%b data=%h", out_valid, out_data);
        @(negedge clk);
        rst_n = 1'b1;
        b_valid = 1'b1; b_data = 8'h66; out_ready = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_tie: ar=%b br=%b want ar=1 br=0", a_ready, b_ready);
        end
        exp_q.push_back({1'b1, 8'h55});
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        checks++;
        exp_word = exp_q.pop_front();
        if (out_valid !== 1'b1 || {out_sel, out_data} !== exp_word) begin
            errors++;
            $display("FAIL reset_tie_word: valid=%b got %h want %h", out_valid, {out_sel, out_data}, exp_word);
        end
        $display("first tie after reset: sel=%b data=%h", out_sel, out_data);
        tick();
    endtask

    task automatic test_single();
        logic [DATA_W-1:0] pat_data [2];
        logic              pat_a    [2];
        pat_data[0] = 8'h3C; pat_a[0] = 1'b1;
        pat_data[1] = 8'hA5; pat_a[1] = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_valid = pat_a[i];  a_data = pat_data[i];
            b_valid = ~pat_a[i]; b_data = pat_data[i];
            #1;
            checks++;
            if (a_ready !== pat_a[i] || b_ready !== ~pat_a[i]) begin
                errors++;
                $display("FAIL single_ready[%0d]: ar=%b br=%b want ar=%b", i, a_ready, b_ready, pat_a[i]);
            end
            exp_q.push_back({pat_a[i], pat_data[i]});
            tick();
            a_valid = 1'b0; b_valid = 1'b0;
            checks++;
            exp_word = exp_q.pop_front();
            if (out_valid !== 1'b1 || {out_sel, out_data} !== exp_word) begin
                errors++;
                $display("FAIL single_word[%0d]: valid=%b got %h want %h", i, out_valid, {out_sel, out_data}, exp_word);
            end
            $display("single source: sel=%b data=%h", out_sel, out_data);
        end
        tick();
    endtask

    task automatic test_tie();
        logic exp_a;
        a_valid = 1'b1; a_data = 8'h11;
        b_valid = 1'b1; b_data = 8'h22;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp_a = 1'b1;
`else
            exp_a = (i % 2 == 0);
`endif
            #1;
            exp_q.push_back(exp_a ? {1'b1, 8'h11} : {1'b0, 8'h22});
            tick();
            checks++;
            exp_word = exp_q.pop_front();
            if (out_valid !== 1'b1 || {out_sel, out_data} !== exp_word) begin
                errors++;
                $display("FAIL tie_word[%0d]: valid=%b got %h want %h", i, out_valid, {out_sel, out_data}, exp_word);
            end
            $display("tie cycle %0d: sel=%b data=%h", i, out_sel, out_data);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL tie_idle: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b1;
        a_valid = 1'b1; a_data = 8'h77;
        #1;
        exp_q.push_back({1'b1, 8'h77});
        tick();
        checks++;
        exp_word = exp_q.pop_front();
        if (out_valid !== 1'b1 || {out_sel, out_data} !== exp_word) begin
            errors++;
            $display("FAIL bp_first: valid=%b got %h want %h", out_valid, {out_sel, out_data}, exp_word);
        end
        a_valid = 1'b0; b_valid = 1'b1; b_data = 8'h99; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready[%0d]: ar=%b br=%b want 0 0", i, a_ready, b_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || {out_sel, out_data} !== {1'b1, 8'h77}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b got %h want 177", i, out_valid, {out_sel, out_data});
            end
            $display("stall cycle %0d: valid=%b data=%h", i, out_valid, out_data);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: ar=%b br=%b want ar=0 br=1", a_ready, b_ready);
        end
        exp_q.push_back({1'b0, 8'h99});
        tick();
        b_valid = 1'b0;
        checks++;
        exp_word = exp_q.pop_front();
        if (out_valid !== 1'b1 || {out_sel, out_data} !== exp_word) begin
            errors++;
            $display("FAIL bp_reload: valid=%b got %h want %h", out_valid, {out_sel, out_data}, exp_word);
        end
        $display("drain and reload: sel=%b data=%h", out_sel, out_data);
        tick();
    endtask

    task automatic test_last_a_hold();
        out_ready = 1'b1;
        a_valid = 1'b1; a_data = 8'h01;
        #1;
        exp_q.push_back({1'b1, 8'h01});
        tick();
        a_valid = 1'b0;
        checks++;
        exp_word = exp_q.pop_front();
        if (out_valid !== 1'b1 || {out_sel, out_data} !== exp_word) begin
            errors++;
            $display("FAIL hold_grant_a: valid=%b got %h want %h", out_valid, {out_sel, out_data}, exp_word);
        end
        tick();
        tick();
        a_valid = 1'b1; a_data = 8'h02;
        b_valid = 1'b1; b_data = 8'h03;
        for (int i = 0; i < 2; i++) begin
            #1;
`ifdef ARB_FIXED_PRIO_EN
            exp_q.push_back({1'b1, 8'h02});
`else
            exp_q.push_back(i == 0 ? {1'b0, 8'h03} : {1'b1, 8'h02});
`endif
            tick();
            checks++;
            exp_word = exp_q.pop_front();
            if (out_valid !== 1'b1 || {out_sel, out_data} !== exp_word) begin
                errors++;
                $display("FAIL hold_tie[%0d]: valid=%b got %h want %h", i, out_valid, {out_sel, out_data}, exp_word);
            end
            $display("tie after idle %0d: sel=%b data=%h", i, out_sel, out_data);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
    endtask

`ifdef ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        out_ready = 1'b1;
        a_valid = 1'b1; a_data = 8'h44;
        b_valid = 1'b1; b_data = 8'h88;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
                errors++;
                $display("FAIL fixed_ready[%0d]: ar=%b br=%b want ar=1 br=0", i, a_ready, b_ready);
            end
            tick();
        end
        a_valid = 1'b0;
        #1;
        checks++;
        if (b_ready !== 1'b1) begin
            errors++;
            $display("FAIL fixed_b_after: br=%b want 1", b_ready);
        end
        $display("fixed priority: b_ready=%b after a drops", b_ready);
        b_valid = 1'b0;
        tick();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_back_pressure();
        test_last_a_hold();
`ifdef ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d words left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
